// File: rtl/tone_detection.sv
// -----------------------------------------------------------------------------
// tone_detection
//
// Purpose:
//   Converts the five band-pass comparator outputs into a confirmed junction
//   command. Every input is synchronised and edge-detected; rising edges are
//   counted per channel over fixed-length windows. At each window end, every
//   channel is qualified against an edge-count band. A single direction tone
//   that stays qualified for CONFIRM_WINDOWS consecutive windows raises tdEn
//   and sets the direction code on tdDir.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   bp1..bp5   in   asynchronous comparator outputs
//                   (STRAIGHT, LEFT, RIGHT, BACK, HOLD/cancel)
//   tdEn       out  confirmed junction command valid (registered)
//   tdDir      out  direction code 00 STRAIGHT, 01 LEFT, 10 RIGHT, 11 BACK
//   toneValid  out  per-window qualification, bit i-1 belongs to bpi
// -----------------------------------------------------------------------------
module tone_detection #(
  parameter int WINDOW_CYCLES   = 500_000,
  parameter int MIN_EDGES       = 8,
  parameter int MAX_EDGES       = 200,
  parameter int CONFIRM_WINDOWS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bp1,
  input  logic       bp2,
  input  logic       bp3,
  input  logic       bp4,
  input  logic       bp5,
  output logic       tdEn,
  output logic [1:0] tdDir,
  output logic [4:0] toneValid
);

  localparam int NUM_CH   = 5;
  localparam int WIN_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int STREAK_W = (CONFIRM_WINDOWS > 0) ? $clog2(CONFIRM_WINDOWS + 1) : 1;

  localparam logic [WIN_W-1:0]    WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(CONFIRM_WINDOWS);

  // The window total (count + final-cycle edge) can reach 256, so the
  // qualification bounds are compared at 9 bits and clamped to that range.
  localparam int MIN_CLAMP = (MIN_EDGES > 256) ? 256 : ((MIN_EDGES < 0) ? 0 : MIN_EDGES);
  localparam int MAX_CLAMP = (MAX_EDGES > 256) ? 256 : ((MAX_EDGES < 0) ? 0 : MAX_EDGES);
  localparam logic [8:0] MIN_L = 9'(MIN_CLAMP);
  localparam logic [8:0] MAX_L = 9'(MAX_CLAMP);

  // ---------------------------------------------------------------------------
  // Input synchronisers and rising-edge detection
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] bp_raw;
  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;
  logic [NUM_CH-1:0] sync3_q;
  logic [NUM_CH-1:0] rise;

  assign bp_raw = {bp5, bp4, bp3, bp2, bp1};

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_q[gi] <= 1'b0;
          sync2_q[gi] <= 1'b0;
          sync3_q[gi] <= 1'b0;
        end else begin
          sync1_q[gi] <= bp_raw[gi];
          sync2_q[gi] <= sync1_q[gi];
          sync3_q[gi] <= sync2_q[gi];
        end
      end

      // sync3 only exists to give a clean previous value for edge detection.
      assign rise[gi] = sync2_q[gi] & ~sync3_q[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Shared window counter
  // ---------------------------------------------------------------------------
  logic [WIN_W-1:0] win_cnt_q;
  logic             win_end;

  assign win_end = (win_cnt_q == WIN_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_q <= '0;
    end else if (win_end) begin
      win_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_q + WIN_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel saturating edge counters and window qualification
  // ---------------------------------------------------------------------------
  logic [7:0]        cnt_q [NUM_CH];
  logic [NUM_CH-1:0] valid_now;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_count
      logic [8:0] total;

      // An edge seen in the window's last cycle still belongs to the closing
      // window, so it is added here rather than into the cleared counter.
      assign total         = {1'b0, cnt_q[gi]} + {8'd0, rise[gi]};
      assign valid_now[gi] = (total >= MIN_L) && (total <= MAX_L);

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q[gi] <= 8'd0;
        end else if (win_end) begin
          cnt_q[gi] <= 8'd0;
        end else if (rise[gi] && (cnt_q[gi] != 8'hFF)) begin
          cnt_q[gi] <= cnt_q[gi] + 8'd1;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Direction decode: exactly one of the four direction channels qualified
  // ---------------------------------------------------------------------------
  logic [3:0] dir_vec;
  logic       dir_single;
  logic [1:0] dir_code;

  assign dir_vec    = valid_now[3:0];
  // Non-zero and a power of two means exactly one bit set.
  assign dir_single = (dir_vec != 4'd0) && ((dir_vec & (dir_vec - 4'd1)) == 4'd0);

  always_comb begin
    dir_code = 2'd0;
    unique case (dir_vec)
      4'b0010: dir_code = 2'd1;
      4'b0100: dir_code = 2'd2;
      4'b1000: dir_code = 2'd3;
      default: dir_code = 2'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Confirmation state and registered outputs
  // ---------------------------------------------------------------------------
  logic [1:0]          cand_q,   cand_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                en_q,     en_d;
  logic [1:0]          dir_q,    dir_d;
  logic [NUM_CH-1:0]   tv_q,     tv_d;

  always_comb begin
    cand_d   = cand_q;
    streak_d = streak_q;
    en_d     = en_q;
    dir_d    = dir_q;
    tv_d     = tv_q;

    if (win_end) begin
      tv_d = valid_now;

      if (valid_now[4]) begin
        // The HOLD tone cancels any pending or confirmed command.
        streak_d = '0;
      end else if (dir_single) begin
        if ((dir_code == cand_q) && (streak_q != '0)) begin
          streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : (streak_q + STREAK_W'(1));
        end else begin
          cand_d   = dir_code;
          streak_d = STREAK_W'(1);
        end
      end else begin
        streak_d = '0;
      end

      // tdDir is only loaded together with a rising or continuing tdEn, so
      // it keeps the last confirmed direction while tdEn is low.
      if (streak_d == STREAK_MAX) begin
        en_d  = 1'b1;
        dir_d = cand_d;
      end else begin
        en_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q   <= 2'd0;
      streak_q <= '0;
      en_q     <= 1'b0;
      dir_q    <= 2'd0;
      tv_q     <= '0;
    end else begin
      cand_q   <= cand_d;
      streak_q <= streak_d;
      en_q     <= en_d;
      dir_q    <= dir_d;
      tv_q     <= tv_d;
    end
  end

  assign tdEn      = en_q;
  assign tdDir     = dir_q;
  assign toneValid = tv_q;

endmodule

// File: tb/tb_tone_detection.sv
// -----------------------------------------------------------------------------
// tb_tone_detection
//
// Purpose:
//   Self-checking bench for tone_detection with a 100-cycle window.
//   A table of per-window stimulus records with hand-derived expected outputs
//   covers reset, single tone, ambiguity, bounds, direction change and cancel.
//   Randomised windows are then checked against a window-level reference model.
//   The model counts rising input transitions per window, shifted by the
//   3-cycle input latency, and decides tdEn from the history of qualified
//   windows.
// -----------------------------------------------------------------------------
module tb_tone_detection;

  localparam int W     = 100;
  localparam int MINE  = 4;
  localparam int MAXE  = 40;
  localparam int CONF  = 3;
  localparam int MAXW  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bp1 = 1'b0;
  logic       bp2 = 1'b0;
  logic       bp3 = 1'b0;
  logic       bp4 = 1'b0;
  logic       bp5 = 1'b0;
  logic       tdEn;
  logic [1:0] tdDir;
  logic [4:0] toneValid;

  always #5 clk = ~clk;

  tone_detection #(
    .WINDOW_CYCLES  (W),
    .MIN_EDGES      (MINE),
    .MAX_EDGES      (MAXE),
    .CONFIRM_WINDOWS(CONF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bp1      (bp1),
    .bp2      (bp2),
    .bp3      (bp3),
    .bp4      (bp4),
    .bp5      (bp5),
    .tdEn     (tdEn),
    .tdDir    (tdDir),
    .toneValid(toneValid)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int         cyc;
  logic [4:0] prev_lev;
  int         wcnt [MAXW][5];
  bit         ok_hist [MAXW];
  logic [1:0] code_hist [MAXW];
  logic [4:0] exp_tv;
  logic       exp_en;
  logic [1:0] exp_dir;

  typedef struct {
    bit         rst_first;
    logic [39:0] ns;       // {n5,n4,n3,n2,n1}: edges per channel this window
    logic [4:0] tv;
    logic       en;
    logic [1:0] dir;
  } vec_t;

  vec_t tbl [27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] ns5(input int a, input int b, input int c, input int d, input int e);
    return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic vec_t mk(input bit r, input logic [39:0] ns, input logic [4:0] tv,
                              input logic en, input logic [1:0] dir);
    vec_t v;
    v.rst_first = r;
    v.ns        = ns;
    v.tv        = tv;
    v.en        = en;
    v.dir       = dir;
    return v;
  endfunction

  // n one-cycle pulses: 10-cycle period when they fit, otherwise every 2 cycles.
  function automatic logic [W-1:0] burst(input int n, input int start);
    logic [W-1:0] p;
    int step;
    p    = '0;
    step = (n * 10 <= W) ? 10 : 2;
    for (int i = 0; i < n; i++) begin
      if (start + i * step < W) p[start + i * step] = 1'b1;
    end
    return p;
  endfunction

  // Drive one input cycle and record any rising transition in the window
  // where it becomes visible three cycles later.
  task automatic drive_level(input logic [4:0] lev);
    {bp5, bp4, bp3, bp2, bp1} = lev;
    for (int ch = 0; ch < 5; ch++) begin
      if (lev[ch] && !prev_lev[ch]) begin
        int idx;
        idx = (cyc + 3) / W;
        if (idx < MAXW) wcnt[idx][ch]++;
      end
    end
    prev_lev = lev;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      {bp5, bp4, bp3, bp2, bp1} = (i % 2 == 0) ? 5'b11111 : 5'b00000;
      @(negedge clk);
      check("rst_tdEn", 32'(tdEn), 32'd0);
      check("rst_tdDir", 32'(tdDir), 32'd0);
      check("rst_toneValid", 32'(toneValid), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    {bp5, bp4, bp3, bp2, bp1} = 5'b00000;
    cyc      = 0;
    prev_lev = '0;
    for (int k = 0; k < MAXW; k++) begin
      ok_hist[k]   = 1'b0;
      code_hist[k] = 2'd0;
      for (int ch = 0; ch < 5; ch++) wcnt[k][ch] = 0;
    end
    exp_tv  = '0;
    exp_en  = 1'b0;
    exp_dir = 2'd0;
  endtask

  // Run window k: outputs must hold the previous window's result throughout,
  // then the model is advanced by one window end.
  task automatic run_window(input int k, input logic [4:0][W-1:0] plan);
    logic [4:0] lev;
    int ones;
    bit all_same;
    for (int c = 0; c < W; c++) begin
      @(posedge clk);
      #1;
      for (int ch = 0; ch < 5; ch++) lev[ch] = plan[ch][c];
      drive_level(lev);
      if (c == W / 2 || c == W - 2) begin
        @(negedge clk);
        check("hold_toneValid", 32'(toneValid), 32'(exp_tv));
        check("hold_tdEn", 32'(tdEn), 32'(exp_en));
        check("hold_tdDir", 32'(tdDir), 32'(exp_dir));
      end
    end
    @(negedge clk);
    for (int ch = 0; ch < 5; ch++) exp_tv[ch] = (wcnt[k][ch] >= MINE) && (wcnt[k][ch] <= MAXE);
    ones = 0;
    for (int ch = 0; ch < 4; ch++) begin
      if (exp_tv[ch]) begin
        ones++;
        code_hist[k] = 2'(ch);
      end
    end
    ok_hist[k] = !exp_tv[4] && (ones == 1);
    all_same = (k >= CONF - 1);
    if (all_same) begin
      for (int j = k - CONF + 1; j <= k; j++) begin
        if (!ok_hist[j] || code_hist[j] != code_hist[k]) all_same = 1'b0;
      end
    end
    exp_en = all_same;
    if (all_same) exp_dir = code_hist[k];
    $display("window %0d: toneValid=%b tdEn=%b tdDir=%b (model %b %b %b)",
             k, toneValid, tdEn, tdDir, exp_tv, exp_en, exp_dir);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [4:0][W-1:0] plan;
    int k;
    int dom;

    // single tone on bp2
    tbl[0]  = mk(1, ns5(0,10,0,0,0),  5'b00010, 0, 2'd0);
    tbl[1]  = mk(0, ns5(0,10,0,0,0),  5'b00010, 0, 2'd0);
    tbl[2]  = mk(0, ns5(0,10,0,0,0),  5'b00010, 1, 2'd1);
    tbl[3]  = mk(0, ns5(0,10,0,0,0),  5'b00010, 1, 2'd1);
    // direction change bp1 -> bp4
    tbl[4]  = mk(1, ns5(10,0,0,0,0),  5'b00001, 0, 2'd0);
    tbl[5]  = mk(0, ns5(10,0,0,0,0),  5'b00001, 0, 2'd0);
    tbl[6]  = mk(0, ns5(10,0,0,0,0),  5'b00001, 1, 2'd0);
    tbl[7]  = mk(0, ns5(10,0,0,0,0),  5'b00001, 1, 2'd0);
    tbl[8]  = mk(0, ns5(0,0,0,10,0),  5'b01000, 0, 2'd0);
    tbl[9]  = mk(0, ns5(0,0,0,10,0),  5'b01000, 0, 2'd0);
    tbl[10] = mk(0, ns5(0,0,0,10,0),  5'b01000, 1, 2'd3);
    // cancel with bp5
    tbl[11] = mk(1, ns5(0,10,0,0,0),  5'b00010, 0, 2'd0);
    tbl[12] = mk(0, ns5(0,10,0,0,0),  5'b00010, 0, 2'd0);
    tbl[13] = mk(0, ns5(0,10,0,0,0),  5'b00010, 1, 2'd1);
    tbl[14] = mk(0, ns5(0,10,0,0,10), 5'b10010, 0, 2'd1);
    tbl[15] = mk(0, ns5(0,10,0,0,0),  5'b00010, 0, 2'd1);
    tbl[16] = mk(0, ns5(0,10,0,0,0),  5'b00010, 0, 2'd1);
    tbl[17] = mk(0, ns5(0,10,0,0,0),  5'b00010, 1, 2'd1);
    // ambiguity bp1 + bp3
    tbl[18] = mk(1, ns5(10,0,10,0,0), 5'b00101, 0, 2'd0);
    tbl[19] = mk(0, ns5(10,0,10,0,0), 5'b00101, 0, 2'd0);
    tbl[20] = mk(0, ns5(10,0,10,0,0), 5'b00101, 0, 2'd0);
    tbl[21] = mk(0, ns5(10,0,10,0,0), 5'b00101, 0, 2'd0);
    // bounds on bp3: 3, 4, 40, 50 (chatter), then 4 (+1 spill from chatter)
    tbl[22] = mk(1, ns5(0,0,3,0,0),   5'b00000, 0, 2'd0);
    tbl[23] = mk(0, ns5(0,0,4,0,0),   5'b00100, 0, 2'd0);
    tbl[24] = mk(0, ns5(0,0,40,0,0),  5'b00100, 0, 2'd0);
    tbl[25] = mk(0, ns5(0,0,50,0,0),  5'b00000, 0, 2'd0);
    tbl[26] = mk(0, ns5(0,0,4,0,0),   5'b00100, 0, 2'd0);

    k = 0;
    for (int r = 0; r < 27; r++) begin
      if (tbl[r].rst_first) begin
        do_reset();
        k = 0;
      end
      for (int ch = 0; ch < 5; ch++) plan[ch] = burst(int'(tbl[r].ns[8*ch +: 8]), 0);
      run_window(k, plan);
      check($sformatf("tbl%0d_toneValid", r), 32'(toneValid), 32'(tbl[r].tv));
      check($sformatf("tbl%0d_tdEn", r), 32'(tdEn), 32'(tbl[r].en));
      check($sformatf("tbl%0d_tdDir", r), 32'(tdDir), 32'(tbl[r].dir));
      k++;
    end

    // Randomised windows against the reference model
    for (int s = 0; s < 3; s++) begin
      do_reset();
      dom = int'($urandom_range(0, 3));
      for (int kw = 0; kw < 12; kw++) begin
        if ($urandom_range(0, 3) == 0) dom = int'($urandom_range(0, 4));
        for (int ch = 0; ch < 5; ch++) begin
          int n;
          int step;
          int hi;
          n = 0;
          if (ch == dom) n = int'($urandom_range(MINE - 1, MAXE + 2));
          else if ($urandom_range(0, 4) == 0) n = int'($urandom_range(0, 50));
          step = (n * 10 <= W) ? 10 : 2;
          hi = (n > 0) ? (W - 1 - step * (n - 1)) : 0;
          if (hi < 0) hi = 0;
          plan[ch] = burst(n, int'($urandom_range(0, hi)));
        end
        run_window(kw, plan);
        check("rnd_toneValid", 32'(toneValid), 32'(exp_tv));
        check("rnd_tdEn", 32'(tdEn), 32'(exp_en));
        check("rnd_tdDir", 32'(tdDir), 32'(exp_dir));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
